alu_mdu: RTL

Parametrised execute-stage ALU with an integrated multiply/divide unit and HI/LO registers. Single-cycle ops (logic, add/sub, shifts, compare, LUI) return results combinationally. MULT/MULTU/DIV/DIVU run as an iterative multi-cycle operation that raises `busy` so the pipeline controller can stall. It sits in EX beside the forwarding muxes and replaces the plain ALU there.

---
 rtl/alu_mdu_pkg.sv | 38 +++
 rtl/alu_mdu_if.sv | 30 +++
 rtl/alu_md_core.sv | 111 +++++++++++
 rtl/alu_mdu.sv | 95 +++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared control codes for the execute-stage ALU / multiply-divide unit.
// Every block that decodes `op` imports this package so the codes are defined in one place.
package alu_mdu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] AND_CONTROL   = 5'd0;
  localparam logic [OP_W-1:0] OR_CONTROL    = 5'd1;
  localparam logic [OP_W-1:0] XOR_CONTROL   = 5'd2;
  localparam logic [OP_W-1:0] NOR_CONTROL   = 5'd3;
  localparam logic [OP_W-1:0] ADD_CONTROL   = 5'd4;
  localparam logic [OP_W-1:0] ADDU_CONTROL  = 5'd5;
  localparam logic [OP_W-1:0] SUB_CONTROL   = 5'd6;
  localparam logic [OP_W-1:0] SUBU_CONTROL  = 5'd7;
  localparam logic [OP_W-1:0] SLT_CONTROL   = 5'd8;
  localparam logic [OP_W-1:0] SLTU_CONTROL  = 5'd9;
  localparam logic [OP_W-1:0] SLL_CONTROL   = 5'd10;
  localparam logic [OP_W-1:0] SRL_CONTROL   = 5'd11;
  localparam logic [OP_W-1:0] SRA_CONTROL   = 5'd12;
  localparam logic [OP_W-1:0] SLLV_CONTROL  = 5'd13;
  localparam logic [OP_W-1:0] SRLV_CONTROL  = 5'd14;
  localparam logic [OP_W-1:0] SRAV_CONTROL  = 5'd15;
  localparam logic [OP_W-1:0] LUI_CONTROL   = 5'd16;
  localparam logic [OP_W-1:0] MFHI_CONTROL  = 5'd17;
  localparam logic [OP_W-1:0] MFLO_CONTROL  = 5'd18;
  localparam logic [OP_W-1:0] MTHI_CONTROL  = 5'd19;
  localparam logic [OP_W-1:0] MTLO_CONTROL  = 5'd20;
  localparam logic [OP_W-1:0] MULT_CONTROL  = 5'd21;
  localparam logic [OP_W-1:0] MULTU_CONTROL = 5'd22;
  localparam logic [OP_W-1:0] DIV_CONTROL   = 5'd23;
  localparam logic [OP_W-1:0] DIVU_CONTROL  = 5'd24;

  function automatic logic is_md_op(input logic [OP_W-1:0] op);
    return (op == MULT_CONTROL) || (op == MULTU_CONTROL) ||
           (op == DIV_CONTROL)  || (op == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Operand/result bundle between the EX stage and the ALU/MDU.
// `master` is the pipeline side that drives operands, `slave` is the unit itself.
interface alu_mdu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic             start;
  logic             cancel;
  logic [4:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   sa;
  logic [WIDTH-1:0] res;
  logic             overflow;
  logic             zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, cancel, op, a, b, sa,
    input  res, overflow, zero, busy, done, hi, lo
  );

  modport slave (
    input  start, cancel, op, a, b, sa,
    output res, overflow, zero, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_md_core.sv
// Iterative radix-2 multiply / restoring divide engine with sign fix-up.
// Works on unsigned magnitudes; signs are reapplied in the FIX state.
module alu_md_core
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic             is_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             wr_en
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} md_state_e;

  md_state_e          state, state_next;
  logic [2*WIDTH-1:0] acc, acc_next, prod;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mb_q, mag_a, mag_b, quo, rem;
  logic [WIDTH:0]     mul_sum, div_diff;
  logic               neg_a_q, neg_b_q, div_q, dz_q, accept;

  assign accept = (state == IDLE) && start && !cancel;
  assign mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    wr_en      = 1'b0;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN: begin
        if (cancel)          state_next = IDLE;
        else if (cnt == '0)  state_next = FIX;
      end
      FIX: begin
        state_next = IDLE;
        wr_en      = !cancel;
      end
      default: state_next = IDLE;
    endcase
  end

  // Both ops start with the A magnitude in the low half; B is the addend or divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      mb_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == FIX) && !cancel;
      if (accept) begin
        acc     <= {{WIDTH{1'b0}}, mag_a};
        mb_q    <= mag_b;
        cnt     <= CW'(WIDTH - 1);
        neg_a_q <= sgn & a[WIDTH-1];
        neg_b_q <= sgn & b[WIDTH-1];
        div_q   <= is_div;
        dz_q    <= (b == '0);
      end else if (state == RUN) begin
        acc <= acc_next;
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb_q} : '0);
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb_q};
    if (div_q)
      acc_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};

    prod = (neg_a_q ^ neg_b_q) ? -acc : acc;
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    // Remainder follows the dividend sign, which also makes a divide by zero return A in HI.
    if (div_q) begin
      hi_out = neg_a_q ? -rem : rem;
      lo_out = dz_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quo : quo);
    end else begin
      hi_out = prod[2*WIDTH-1:WIDTH];
      lo_out = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU: single-cycle combinational ops plus HI/LO registers
// fed by the iterative multiply/divide core and by MTHI/MTLO.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  alu_mdu_if.slave  bus
);

  logic [WIDTH-1:0] hi_q, lo_q, md_hi, md_lo, res_c, add_sum, sub_diff;
  logic             md_start, md_sgn, md_div, md_wr, md_busy, md_done, ov_c;

  assign md_start = bus.start && is_md_op(bus.op);
  assign md_sgn   = (bus.op == MULT_CONTROL) || (bus.op == DIV_CONTROL);
  assign md_div   = (bus.op == DIV_CONTROL)  || (bus.op == DIVU_CONTROL);

  alu_md_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .sgn    (md_sgn),
    .is_div (md_div),
    .cancel (bus.cancel),
    .a      (bus.a),
    .b      (bus.b),
    .busy   (md_busy),
    .done   (md_done),
    .hi_out (md_hi),
    .lo_out (md_lo),
    .wr_en  (md_wr)
  );

  // MT writes can only land while the core is idle, so they never collide with md_wr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (md_wr) begin
      hi_q <= md_hi;
      lo_q <= md_lo;
    end else if (bus.start && !md_busy && !bus.cancel) begin
      if (bus.op == MTHI_CONTROL) hi_q <= bus.a;
      if (bus.op == MTLO_CONTROL) lo_q <= bus.a;
    end
  end

  assign add_sum  = bus.a + bus.b;
  assign sub_diff = bus.a - bus.b;

  always_comb begin
    res_c = '0;
    ov_c  = 1'b0;
    case (bus.op)
      AND_CONTROL:  res_c = bus.a & bus.b;
      OR_CONTROL:   res_c = bus.a | bus.b;
      XOR_CONTROL:  res_c = bus.a ^ bus.b;
      NOR_CONTROL:  res_c = ~(bus.a | bus.b);
      ADD_CONTROL: begin
        res_c = add_sum;
        ov_c  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ADDU_CONTROL: res_c = add_sum;
      SUB_CONTROL: begin
        res_c = sub_diff;
        ov_c  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      SUBU_CONTROL: res_c = sub_diff;
      SLT_CONTROL:  res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      SLTU_CONTROL: res_c = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      SLL_CONTROL:  res_c = bus.b << bus.sa;
      SRL_CONTROL:  res_c = bus.b >> bus.sa;
      SRA_CONTROL:  res_c = $signed(bus.b) >>> bus.sa;
      SLLV_CONTROL: res_c = bus.b << bus.a[SHW-1:0];
      SRLV_CONTROL: res_c = bus.b >> bus.a[SHW-1:0];
      SRAV_CONTROL: res_c = $signed(bus.b) >>> bus.a[SHW-1:0];
      LUI_CONTROL:  res_c = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      MFHI_CONTROL: res_c = hi_q;
      MFLO_CONTROL: res_c = lo_q;
      default:      res_c = '0;
    endcase
  end

  assign bus.res      = res_c;
  assign bus.overflow = ov_c;
  assign bus.zero     = (res_c == '0);
  assign bus.busy     = md_busy;
  assign bus.done     = md_done;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule
